// File: rtl/break_trig_pkg.sv
// Shared encodings for the commit-stream breakpoint trigger:
// trigger modes and FSM states.
package break_trig_pkg;

    typedef enum logic [1:0] {
        MODE_PC      = 2'd0,
        MODE_CNT     = 2'd1,
        MODE_DATA    = 2'd2,
        MODE_PC_DATA = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } trig_state_e;

endpackage

// File: rtl/commit_matcher.sv
// Combinational hit/fire decision for one commit, evaluated against
// the latched (shadow) trigger configuration.
module commit_matcher
    import break_trig_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 64
) (
    input  mode_e             mode,
    input  logic [XLEN-1:0]   cfg_pc,
    input  logic [XLEN-1:0]   cfg_data,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic [XLEN-1:0]   commit_pc,
    input  logic [XLEN-1:0]   commit_wdata,
    input  logic [CNT_W-1:0]  commit_cnt,
    input  logic [CNT_W-1:0]  hit_cnt,
    output logic              hit,
    output logic              fire
);

    logic             pc_eq;
    logic             data_eq;
    logic [CNT_W:0]   next_cnt;
    logic [CNT_W:0]   cnt_target;

    always_comb begin
        pc_eq    = (commit_pc == cfg_pc);
        data_eq  = (commit_wdata == cfg_data);
        // One extra bit so a saturated commit_cnt never wraps into a false match.
        next_cnt = {1'b0, commit_cnt} + {{CNT_W{1'b0}}, 1'b1};
        if (cfg_count == '0)
            cnt_target = {{CNT_W{1'b0}}, 1'b1};
        else
            cnt_target = {1'b0, cfg_count};

        hit = 1'b0;
        case (mode)
            MODE_PC:      hit = pc_eq;
            MODE_CNT:     hit = (next_cnt == cnt_target);
            MODE_DATA:    hit = data_eq;
            MODE_PC_DATA: hit = pc_eq && data_eq;
            default:      hit = 1'b0;
        endcase

        fire = hit && ((mode == MODE_CNT) || (hit_cnt == cfg_count));
    end

endmodule

// File: rtl/commit_break_trigger.sv
// Commit-stream breakpoint trigger: arms on host config, watches commits,
// raises and holds difftest_break until acknowledged or disarmed.
module commit_break_trigger
    import break_trig_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 64
) (
    input  logic              sys_clk,
    input  logic              sys_resetn,
    input  logic              cfg_arm,
    input  logic              cfg_disarm,
    input  logic [1:0]        cfg_mode,
    input  logic [XLEN-1:0]   cfg_pc,
    input  logic [XLEN-1:0]   cfg_data,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic              commit_valid,
    input  logic [XLEN-1:0]   commit_pc,
    input  logic [XLEN-1:0]   commit_wdata,
    input  logic              break_ack,
    output logic              difftest_break,
    output logic [XLEN-1:0]   break_pc,
    output logic [XLEN-1:0]   break_wdata,
    output logic [CNT_W-1:0]  commit_cnt,
    output logic [1:0]        trig_state
);

    trig_state_e       state;
    mode_e             sh_mode;
    logic [XLEN-1:0]   sh_pc;
    logic [XLEN-1:0]   sh_data;
    logic [CNT_W-1:0]  sh_count;
    logic [CNT_W-1:0]  hit_cnt;
    logic              hit;
    logic              fire;

    commit_matcher #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_matcher (
        .mode         (sh_mode),
        .cfg_pc       (sh_pc),
        .cfg_data     (sh_data),
        .cfg_count    (sh_count),
        .commit_pc    (commit_pc),
        .commit_wdata (commit_wdata),
        .commit_cnt   (commit_cnt),
        .hit_cnt      (hit_cnt),
        .hit          (hit),
        .fire         (fire)
    );

    assign trig_state = state;

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state          <= IDLE;
            difftest_break <= 1'b0;
            break_pc       <= '0;
            break_wdata    <= '0;
            commit_cnt     <= '0;
            hit_cnt        <= '0;
            sh_mode        <= MODE_PC;
            sh_pc          <= '0;
            sh_data        <= '0;
            sh_count       <= '0;
        end else if (cfg_disarm) begin
            // Disarm outranks arm, ack and any firing commit in the same cycle.
            state          <= IDLE;
            difftest_break <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_arm) begin
                        state      <= ARMED;
                        sh_mode    <= mode_e'(cfg_mode);
                        sh_pc      <= cfg_pc;
                        sh_data    <= cfg_data;
                        sh_count   <= cfg_count;
                        commit_cnt <= '0;
                        hit_cnt    <= '0;
                    end
                end
                ARMED: begin
                    if (cfg_arm) begin
                        sh_mode    <= mode_e'(cfg_mode);
                        sh_pc      <= cfg_pc;
                        sh_data    <= cfg_data;
                        sh_count   <= cfg_count;
                        commit_cnt <= '0;
                        hit_cnt    <= '0;
                    end else if (commit_valid) begin
                        if (commit_cnt != '1)
                            commit_cnt <= commit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (fire) begin
                            state          <= FIRED;
                            difftest_break <= 1'b1;
                            break_pc       <= commit_pc;
                            break_wdata    <= commit_wdata;
                        end else if (hit && (sh_mode != MODE_CNT)) begin
                            hit_cnt <= hit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                FIRED: begin
                    if (break_ack) begin
                        state          <= IDLE;
                        difftest_break <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    difftest_break <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_commit_break_trigger.sv
// Directed bench for commit_break_trigger; expected fire events are queued by
// the stimulus and checked by an independent monitor on each break rise.
module tb_commit_break_trigger;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 64;

    logic              sys_clk;
    logic              sys_resetn;
    logic              cfg_arm;
    logic              cfg_disarm;
    logic [1:0]        cfg_mode;
    logic [XLEN-1:0]   cfg_pc;
    logic [XLEN-1:0]   cfg_data;
    logic [CNT_W-1:0]  cfg_count;
    logic              commit_valid;
    logic [XLEN-1:0]   commit_pc;
    logic [XLEN-1:0]   commit_wdata;
    logic              break_ack;
    logic              difftest_break;
    logic [XLEN-1:0]   break_pc;
    logic [XLEN-1:0]   break_wdata;
    logic [CNT_W-1:0]  commit_cnt;
    logic [1:0]        trig_state;

    commit_break_trigger #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_resetn     (sys_resetn),
        .cfg_arm        (cfg_arm),
        .cfg_disarm     (cfg_disarm),
        .cfg_mode       (cfg_mode),
        .cfg_pc         (cfg_pc),
        .cfg_data       (cfg_data),
        .cfg_count      (cfg_count),
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_wdata   (commit_wdata),
        .break_ack      (break_ack),
        .difftest_break (difftest_break),
        .break_pc       (break_pc),
        .break_wdata    (break_wdata),
        .commit_cnt     (commit_cnt),
        .trig_state     (trig_state)
    );

    typedef struct {
        logic [63:0] pc;
        logic [63:0] wdata;
        logic [63:0] cnt;
        int          cyc;
    } fire_t;

    fire_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    logic  prev_break  = 1'b0;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every rising break must match the oldest queued fire event.
    always @(negedge sys_clk) begin
        if (difftest_break && !prev_break) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_fire_pc", break_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                fire_t e;
                e = exp_q.pop_front();
                chk("fire_pc",    break_pc,    e.pc);
                chk("fire_wdata", break_wdata, e.wdata);
                chk("fire_cnt",   commit_cnt,  e.cnt);
                chk("fire_cycle", 64'(cyc),    64'(e.cyc));
            end
        end
        prev_break = difftest_break;
    end

    task automatic step(input logic arm, input logic disarm, input logic ack,
                        input logic valid, input logic [63:0] pc, input logic [63:0] wd);
        cfg_arm      = arm;
        cfg_disarm   = disarm;
        break_ack    = ack;
        commit_valid = valid;
        commit_pc    = pc;
        commit_wdata = wd;
        @(posedge sys_clk);
        #1;
        cfg_arm      = 1'b0;
        cfg_disarm   = 1'b0;
        break_ack    = 1'b0;
        commit_valid = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    task automatic commit(input logic [63:0] pc, input logic [63:0] wd);
        step(1'b0, 1'b0, 1'b0, 1'b1, pc, wd);
    endtask

    task automatic expect_fire_commit(input logic [63:0] pc, input logic [63:0] wd,
                                      input logic [63:0] cnt);
        fire_t e;
        e.pc = pc; e.wdata = wd; e.cnt = cnt; e.cyc = cyc + 1;
        exp_q.push_back(e);
        commit(pc, wd);
    endtask

    task automatic arm(input logic [1:0] mode, input logic [63:0] pc,
                       input logic [63:0] data, input logic [63:0] count);
        cfg_mode  = mode;
        cfg_pc    = pc;
        cfg_data  = data;
        cfg_count = count;
        step(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    initial begin
        sys_resetn   = 1'b0;
        cfg_arm      = 1'b0;
        cfg_disarm   = 1'b0;
        cfg_mode     = 2'd0;
        cfg_pc       = '0;
        cfg_data     = '0;
        cfg_count    = '0;
        commit_valid = 1'b0;
        commit_pc    = '0;
        commit_wdata = '0;
        break_ack    = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_break", 64'(difftest_break), 64'd0);
        chk("rst_pc",    break_pc,            64'd0);
        chk("rst_wdata", break_wdata,         64'd0);
        chk("rst_cnt",   commit_cnt,          64'd0);
        chk("rst_state", 64'(trig_state),     64'd0);
        sys_resetn = 1'b1;
        idle();

        // Mode 0, fire on first PC hit.
        arm(2'd0, 64'h8000_0010, 64'h0, 64'd0);
        chk("armed_state", 64'(trig_state), 64'd1);
        commit(64'h8000_0000, 64'h1);
        idle();
        commit(64'h8000_0004, 64'h2);
        expect_fire_commit(64'h8000_0010, 64'hAA, 64'd3);
        chk("m0_state", 64'(trig_state), 64'd2);
        commit(64'h8000_0010, 64'hBB);
        commit(64'h8000_0014, 64'hCC);
        chk("m0_cnt_frozen", commit_cnt,  64'd3);
        chk("m0_wdata_hold", break_wdata, 64'hAA);
        chk("m0_break_held", 64'(difftest_break), 64'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0);
        chk("ack_break", 64'(difftest_break), 64'd0);
        chk("ack_state", 64'(trig_state),     64'd0);
        commit(64'h8000_0010, 64'hDD);
        chk("idle_cnt",  commit_cnt,       64'd3);
        chk("idle_pc",   break_pc,         64'h8000_0010);
        step(1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0);
        chk("arm_disarm_state", 64'(trig_state), 64'd0);

        // Mode 0 with two skipped hits: third hit fires.
        arm(2'd0, 64'h8000_0010, 64'h0, 64'd2);
        chk("m0s_cnt_clr", commit_cnt, 64'd0);
        commit(64'h8000_0010, 64'h1);
        commit(64'h8000_0020, 64'h2);
        commit(64'h8000_0010, 64'h3);
        commit(64'h8000_0030, 64'h4);
        expect_fire_commit(64'h8000_0010, 64'h5, 64'd5);
        step(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0);

        // Mode 1, count 5, with a restart that swallows its commit.
        arm(2'd1, 64'h0, 64'h0, 64'd5);
        commit(64'h100, 64'h0);
        idle();
        commit(64'h104, 64'h0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 64'h108, 64'h0);
        chk("restart_cnt", commit_cnt, 64'd0);
        commit(64'h200, 64'h10);
        idle();
        commit(64'h204, 64'h11);
        idle();
        idle();
        commit(64'h208, 64'h12);
        commit(64'h20C, 64'h13);
        idle();
        expect_fire_commit(64'h210, 64'h14, 64'd5);
        commit(64'h214, 64'h15);
        commit(64'h218, 64'h16);
        chk("m1_cnt_frozen", commit_cnt, 64'd5);
        step(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0);

        // Mode 3, PC alone or wdata alone is not a hit.
        arm(2'd3, 64'h8000_0100, 64'hDEAD, 64'd0);
        commit(64'h8000_0100, 64'hBEEF);
        commit(64'h8000_0104, 64'hDEAD);
        chk("m3_no_fire", 64'(trig_state), 64'd1);
        expect_fire_commit(64'h8000_0100, 64'hDEAD, 64'd3);
        step(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0);

        // Disarm coinciding with a would-be firing commit: no fire, no capture.
        arm(2'd2, 64'h0, 64'h55, 64'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 64'h9000_0000, 64'h55);
        chk("disarm_state", 64'(trig_state), 64'd0);
        chk("disarm_pc",    break_pc,        64'h8000_0100);

        // Mode 1 with count 0 behaves as count 1, then async reset while fired.
        arm(2'd1, 64'h0, 64'h0, 64'd0);
        expect_fire_commit(64'h9000_0040, 64'h77, 64'd1);
        idle();
        chk("pre_rst_break", 64'(difftest_break), 64'd1);
        #2;
        sys_resetn = 1'b0;
        #1;
        chk("async_break", 64'(difftest_break), 64'd0);
        chk("async_pc",    break_pc,            64'd0);
        chk("async_wdata", break_wdata,         64'd0);
        chk("async_cnt",   commit_cnt,          64'd0);
        chk("async_state", 64'(trig_state),     64'd0);
        @(posedge sys_clk);
        #1;
        sys_resetn = 1'b1;
        idle();
        idle();

        chk("pending_fires", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
